vc_allocator: RTL



---
 rtl/noc_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/vc_allocator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, flit type codes and the per-VC state encoding.
package noc_pkg;

    localparam int FLIT_W    = 64;
    localparam int N_VC      = 2;
    localparam int TYPE_HI   = 57;
    localparam int TYPE_LO   = 55;
    localparam int PKT_ID_HI = 54;
    localparam int PKT_ID_LO = 48;

    typedef logic [TYPE_HI-TYPE_LO:0] flit_type_t;

    localparam flit_type_t FLIT_HEAD = 3'b000;
    localparam flit_type_t FLIT_BODY = 3'b001;
    localparam flit_type_t FLIT_TAIL = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALLOC  = 2'd1,
        ACTIVE = 2'd2
    } vc_state_e;

    function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
        return flit[TYPE_HI:TYPE_LO];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter with one-hot combinational grant and a registered priority pointer.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Priority passes to the requester that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt_o) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// VC allocator for one input port. States: IDLE = no packet | ALLOC = HEAD seen, waiting
// for a free downstream VC | ACTIVE = owns out_vc[i] until its TAIL leaves the crossbar.
module vc_allocator
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] rc_flit_in,
    input  logic              rc_valid,
    input  logic [1:0]        rc_vc_in,
    input  logic [N_VC-1:0]   ds_vc_status,
    input  logic [FLIT_W-1:0] sw_flit,
    input  logic [1:0]        sw_vc,
    input  logic              sw_valid,
    input  logic              sw_grant,
    output logic [N_VC-1:0]   vc_grant,
    output logic [N_VC-1:0]   out_vc,
    output logic [N_VC-1:0]   ds_busy,
    output logic              proto_err
);
    vc_state_e       state_q [N_VC];
    vc_state_e       state_d [N_VC];
    logic [N_VC-1:0] vc_grant_q, vc_grant_d;
    logic [N_VC-1:0] out_vc_q, out_vc_d;
    logic [N_VC-1:0] ds_busy_q, ds_busy_d;
    logic            proto_err_q, proto_err_d;

    logic [N_VC-1:0] rc_hit, tail_hit, alloc_req, alloc_gnt, ds_free;
    flit_type_t      rc_type;
    logic            tail_dep;
    logic            alloc_ds;
    logic            unused_flit_bits;

    assign rc_type     = flit_type(rc_flit_in);
    assign rc_hit[0]   = rc_valid && (rc_vc_in == 2'd0);
    assign rc_hit[1]   = rc_valid && (rc_vc_in == 2'd1);
    assign tail_dep    = sw_valid && sw_grant && (flit_type(sw_flit) == FLIT_TAIL);
    assign tail_hit[0] = tail_dep && (sw_vc == 2'd0);
    assign tail_hit[1] = tail_dep && (sw_vc == 2'd1);

    // Busy map is the registered one, so a VC freed this cycle is only offered next cycle.
    assign ds_free  = ds_vc_status & ~ds_busy_q;
    assign alloc_ds = ~ds_free[0];

    always_comb begin
        alloc_req = '0;
        for (int i = 0; i < N_VC; i++) begin
            alloc_req[i] = (state_q[i] == ALLOC) && (|ds_free);
        end
    end

    rr_arbiter2 u_arb (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (alloc_req),
        .gnt_o (alloc_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_VC; i++) begin
                state_q[i] <= IDLE;
            end
            vc_grant_q  <= '0;
            out_vc_q    <= '0;
            ds_busy_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_VC; i++) begin
                state_q[i] <= state_d[i];
            end
            vc_grant_q  <= vc_grant_d;
            out_vc_q    <= out_vc_d;
            ds_busy_q   <= ds_busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_VC; i++) begin
            state_d[i] = state_q[i];
        end
        vc_grant_d  = '0;
        out_vc_d    = out_vc_q;
        ds_busy_d   = ds_busy_q;
        proto_err_d = proto_err_q;

        for (int i = 0; i < N_VC; i++) begin
            unique case (state_q[i])
                IDLE: begin
                    if (rc_hit[i]) begin
                        if (rc_type == FLIT_HEAD) begin
                            state_d[i] = ALLOC;
                        end else if (rc_type == FLIT_BODY || rc_type == FLIT_TAIL) begin
                            proto_err_d = 1'b1;
                        end
                    end
                end
                ALLOC: begin
                    if (alloc_gnt[i]) begin
                        state_d[i]          = ACTIVE;
                        out_vc_d[i]         = alloc_ds;
                        ds_busy_d[alloc_ds] = 1'b1;
                        vc_grant_d[i]       = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (tail_hit[i]) begin
                        state_d[i]             = IDLE;
                        ds_busy_d[out_vc_q[i]] = 1'b0;
                    end
                end
                default: state_d[i] = IDLE;
            endcase

            if (tail_hit[i] && state_q[i] != ACTIVE) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        vc_grant  = vc_grant_q;
        out_vc    = out_vc_q;
        ds_busy   = ds_busy_q;
        proto_err = proto_err_q;
    end

    assign unused_flit_bits = ^{rc_flit_in[FLIT_W-1:TYPE_HI+1], rc_flit_in[TYPE_LO-1:0],
                                sw_flit[FLIT_W-1:TYPE_HI+1], sw_flit[TYPE_LO-1:0]};

endmodule
